// File: rtl/uart_tx_dev.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_dev                                                  |
// | Description : Memory-mapped 8N1 UART transmitter with byte FIFO and IRQ.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_dev #(
    parameter int DEPTH       = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int          c_PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  c_DEPTH       = 5'(DEPTH);
    localparam logic [15:0] c_DEFAULT_DIV = 16'(DEFAULT_DIV);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [7:0]      r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [4:0]      r_count;
    logic            r_ovf;
    logic            r_en;
    logic            r_ie;
    logic [15:0]     r_div;
    logic            r_irq;

    logic [1:0]      r_state;
    logic [7:0]      r_shift;
    logic [15:0]     r_bit_div;
    logic [15:0]     r_baud;
    logic [2:0]      r_bit_idx;
    logic            r_txd;

    logic            w_wr_data;
    logic            w_wr_stat;
    logic            w_wr_ctrl;
    logic            w_wr_div;
    logic            w_empty;
    logic            w_full;
    logic            w_busy;
    logic            w_pop;
    logic            w_push;
    logic            w_bit_end;
    logic [4:0]      w_count_nxt;
    logic            w_busy_nxt;
    logic            w_ie_nxt;
    logic            w_irq_nxt;
    logic            w_unused;

    assign w_wr_data = WE && (Addr[1:0] == 2'd0);
    assign w_wr_stat = WE && (Addr[1:0] == 2'd1);
    assign w_wr_ctrl = WE && (Addr[1:0] == 2'd2);
    assign w_wr_div  = WE && (Addr[1:0] == 2'd3);

    assign w_empty   = (r_count == 5'd0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_busy    = (r_state != c_ST_IDLE);
    assign w_pop     = (r_state == c_ST_IDLE) && r_en && !w_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push    = w_wr_data && (!w_full || w_pop);
    assign w_bit_end = (r_baud == (r_bit_div - 16'd1));

    // IRQ is registered from next-cycle state so it tracks empty/busy without lag.
    assign w_count_nxt = r_count + 5'(w_push) - 5'(w_pop);
    assign w_busy_nxt  = w_pop || (w_busy && !((r_state == c_ST_STOP) && w_bit_end));
    assign w_ie_nxt    = w_wr_ctrl ? Din[1] : r_ie;
    assign w_irq_nxt   = w_ie_nxt && (w_count_nxt == 5'd0) && !w_busy_nxt;

    assign w_unused = &{1'b0, Addr[29:2], Din[31:16]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= Din[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
            r_ovf   <= 1'b0;
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_div   <= c_DEFAULT_DIV;
            r_irq   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            r_count <= w_count_nxt;
            if (w_wr_data && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat && Din[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_en <= Din[0];
                r_ie <= Din[1];
            end
            if (w_wr_div) begin
                r_div <= (Din[15:0] == 16'd0) ? 16'd1 : Din[15:0];
            end
            r_irq <= w_irq_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_shift   <= 8'd0;
            r_bit_div <= c_DEFAULT_DIV;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_state   <= c_ST_START;
                        r_shift   <= r_mem[r_rptr];
                        r_bit_div <= r_div;
                        r_baud    <= 16'd0;
                        r_txd     <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_baud    <= 16'd0;
                        r_state   <= c_ST_DATA;
                        r_bit_idx <= 3'd0;
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_ST_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= 16'd0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[1:0])
            2'd1:    Dout = {23'd0, r_count, r_ovf, w_busy, w_empty, w_full};
            2'd2:    Dout = {30'd0, r_ie, r_en};
            2'd3:    Dout = {16'd0, r_div};
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = r_irq;
    assign txd = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_dev.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_dev                                               |
// | Description : Directed/randomised self-checking bench for uart_tx_dev.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_dev;

    logic        clk;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int checks;
    int errors;

    uart_tx_dev #(
        .DEPTH       (8),
        .DEFAULT_DIV (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        Addr = {28'd0, a};
        WE   = 1'b0;
        #1;
        v = Dout;
    endtask

    function automatic logic [31:0] stat_exp(input int cnt, input bit ovf, input bit busy);
        return 32'((cnt << 4) | (int'(ovf) << 3) | (int'(busy) << 2) |
                   (int'(cnt == 0) << 1) | int'(cnt == 8));
    endfunction

    // Waits (bounded) for the first START cycle; returns cycles waited.
    task automatic wait_start(output int waited);
        waited = 0;
        while (txd !== 1'b0 && waited < 400) begin
            tick();
            waited++;
        end
        chk("start_seen", {31'd0, txd}, 32'd0);
    endtask

    // Checks one whole frame from its first START cycle, then the following cycle.
    task automatic frame(input logic [7:0] b, input int div, input string tag,
                         input bit chk_irq, input int wr_at);
        int   bad_txd;
        int   bad_busy;
        int   bad_irq;
        int   idx;
        logic exp_bit;
        bad_txd  = 0;
        bad_busy = 0;
        bad_irq  = 0;
        Addr = 30'd1;
        WE   = 1'b0;
        #1;
        for (int i = 0; i < 10 * div; i++) begin
            idx = i / div;
            exp_bit = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : b[idx-1];
            if (txd !== exp_bit) bad_txd++;
            if (chk_irq && IRQ !== 1'b0) bad_irq++;
            if (i == wr_at) begin
                Addr = 30'd3;
                Din  = 32'd8;
                WE   = 1'b1;
            end else if (Dout[2] !== 1'b1) begin
                bad_busy++;
            end
            tick();
            if (i == wr_at) begin
                WE   = 1'b0;
                Addr = 30'd1;
                #1;
            end
        end
        chk({tag, "_txd_bad_cycles"}, 32'(bad_txd), 32'd0);
        chk({tag, "_busy_bad_cycles"}, 32'(bad_busy), 32'd0);
        if (chk_irq) chk({tag, "_irq_bad_cycles"}, 32'(bad_irq), 32'd0);
        chk({tag, "_gap_txd"}, {31'd0, txd}, 32'd1);
        chk({tag, "_gap_busy"}, {31'd0, Dout[2]}, 32'd0);
    endtask

    logic [31:0] v;
    logic [7:0]  q[$];
    logic [7:0]  b;
    int          w;
    int          div;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        WE     = 1'b0;
        Addr   = 30'd1;
        Din    = 32'd0;

        // Reset state
        #12;
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        chk("rst_stat_in_reset", Dout, 32'h2);
        reset = 1'b1;
        tick();
        rd(2'd0, v); chk("rst_data", v, 32'd0);
        rd(2'd1, v); chk("rst_stat", v, 32'h2);
        rd(2'd2, v); chk("rst_ctrl", v, 32'd0);
        rd(2'd3, v); chk("rst_div", v, 32'd16);

        // Single frame 0x55 at DIV=4
        wr(2'd3, 32'd4);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h55);
        wait_start(w);
        chk("single_latency", 32'(w), 32'd1);
        frame(8'h55, 4, "single", 1'b0, -1);
        tick();

        // IRQ behaviour
        wr(2'd2, 32'd3);
        wr(2'd3, 32'd1);
        chk("irq_idle_empty", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'hA5);
        chk("irq_after_push", {31'd0, IRQ}, 32'd0);
        wait_start(w);
        frame(8'hA5, 1, "irq_frame", 1'b1, -1);
        chk("irq_after_stop", {31'd0, IRQ}, 32'd1);
        b = 8'($urandom);
        wr(2'd0, {24'd0, b});
        chk("irq_second_push", {31'd0, IRQ}, 32'd0);
        wait_start(w);
        frame(b, 1, "irq_frame2", 1'b1, -1);
        chk("irq_after_stop2", {31'd0, IRQ}, 32'd1);
        wr(2'd2, 32'd1);
        chk("irq_ie_clear", {31'd0, IRQ}, 32'd0);
        tick();

        // Overflow, simultaneous push/pop on full, ordered back-to-back frames
        wr(2'd2, 32'd0);
        div = int'($urandom_range(3, 1));
        wr(2'd3, 32'(div));
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            if (i < 8) q.push_back(b);
            wr(2'd0, {24'd0, b});
        end
        rd(2'd1, v); chk("ovf_stat", v, stat_exp(8, 1'b1, 1'b0));
        wr(2'd1, 32'h7);
        rd(2'd1, v); chk("ovf_keep_bit3_0", v, stat_exp(8, 1'b1, 1'b0));
        wr(2'd1, 32'h8);
        rd(2'd1, v); chk("ovf_clear", v, stat_exp(8, 1'b0, 1'b0));
        wr(2'd2, 32'd1);
        b = 8'($urandom);
        q.push_back(b);
        wr(2'd0, {24'd0, b});
        rd(2'd1, v); chk("full_push_pop", v, stat_exp(8, 1'b0, 1'b1));
        for (int k = 0; k < 9; k++) begin
            b = q.pop_front();
            wait_start(w);
            chk($sformatf("b2b_wait_%0d", k), 32'(w), 32'd0);
            frame(b, div, $sformatf("fifo_frame_%0d", k), 1'b0, -1);
            tick();
        end
        rd(2'd1, v); chk("drained_stat", v, stat_exp(0, 1'b0, 1'b0));

        // DIV edge: zero stores 1, mid-frame write affects only the next frame
        wr(2'd3, 32'd0);
        rd(2'd3, v); chk("div_zero_reads_one", v, 32'd1);
        wr(2'd0, 32'hFF);
        wait_start(w);
        frame(8'hFF, 1, "div1_ff", 1'b0, -1);
        tick();
        b = 8'($urandom);
        wr(2'd0, {24'd0, b});
        wait_start(w);
        frame(b, 1, "div_mid_write", 1'b0, 3);
        tick();
        rd(2'd3, v); chk("div_after_mid", v, 32'd8);
        b = 8'($urandom);
        wr(2'd0, {24'd0, b});
        wait_start(w);
        frame(b, 8, "div8", 1'b0, -1);
        tick();

        // Reset mid-frame at the fifth data bit
        wr(2'd3, 32'd4);
        b = 8'($urandom) & 8'hEF;
        wr(2'd0, {24'd0, b});
        wr(2'd0, 32'($urandom & 32'hFF));
        wr(2'd0, 32'($urandom & 32'hFF));
        wait_start(w);
        for (int i = 0; i < 20; i++) tick();
        chk("pre_reset_bit4", {31'd0, txd}, 32'd0);
        Addr  = 30'd1;
        reset = 1'b0;
        #1;
        chk("async_rst_txd", {31'd0, txd}, 32'd1);
        chk("async_rst_irq", {31'd0, IRQ}, 32'd0);
        chk("async_rst_stat", Dout, 32'h2);
        #2;
        reset = 1'b1;
        tick();
        rd(2'd1, v); chk("post_rst_stat", v, 32'h2);
        rd(2'd3, v); chk("post_rst_div", v, 32'd16);
        rd(2'd2, v); chk("post_rst_ctrl", v, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_txd_idle", {31'd0, txd}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
